// File: rtl/xs3_pkg.sv
// Shared constants, state encoding and code-validity helper for the XS3 serial adder.
package xs3_pkg;

  localparam logic [3:0] XS3_ZERO = 4'b0011;
  localparam logic [3:0] XS3_ONE  = 4'b0100;
  localparam logic [3:0] XS3_ADJ  = 4'b0011;

  typedef enum logic {
    ACC,
    FLUSH
  } state_t;

  // Only 0011..1100 encode decimal digits; the six remaining codes are illegal.
  function automatic logic xs3_invalid(input logic [3:0] code);
    return (code < 4'd3) || (code > 4'd12);
  endfunction

endpackage

// File: rtl/xs3_digit_add.sv
// Combinational single-digit Excess-3 adder with carry in/out.
module xs3_digit_add
  import xs3_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] s5;

  // Two XS3 digits carry a bias of 6; a binary carry out means the decimal sum hit 10.
  always_comb begin
    s5   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout = s5[4];
    sum  = s5[4] ? (s5[3:0] + XS3_ADJ) : (s5[3:0] - XS3_ADJ);
  end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial Excess-3 adder, LSD first, with valid/ready on both sides.
// Optional illegal-code detection is enabled by defining XS3_CHECK_EN.
module xs3_serial_adder
  import xs3_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_last,
  output logic       err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  state_t        state;
  logic          carry;
  logic [CW-1:0] count;
  logic          take;
  logic          overflow;
  logic          last_eff;
  logic          code_err;
  logic          err_set;
  logic [3:0]    sum;
  logic          cout;

  assign in_ready = (state == ACC) && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;
  assign overflow = (count == CNT_MAX);
  assign last_eff = in_last || overflow;

`ifdef XS3_CHECK_EN
  assign code_err = xs3_invalid(in_a) || xs3_invalid(in_b);
`else
  assign code_err = 1'b0;
`endif

  assign err_set = overflow || code_err;

  xs3_digit_add u_add (
    .a    (in_a),
    .b    (in_b),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // A last digit that overflows parks in FLUSH so the extra "1" digit follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      carry     <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_digit <= XS3_ZERO;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (take) begin
            out_valid <= 1'b1;
            out_digit <= sum;
            out_last  <= last_eff && !cout;
            if (err_set)
              err <= 1'b1;
            else if (count == '0)
              err <= 1'b0;
            if (last_eff) begin
              carry <= 1'b0;
              count <= '0;
              if (cout)
                state <= FLUSH;
            end else begin
              carry <= cout;
              count <= count + CW'(1);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          if (out_ready) begin
            out_digit <= XS3_ONE;
            out_last  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Self-checking bench for xs3_serial_adder: decimal reference model plus directed corner cases.
module tb_xs3_serial_adder;

  localparam int MAXD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'd0;
  logic [3:0] in_b = 4'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_digit;
  logic       out_last;
  logic       err;

  typedef struct {
    logic [3:0] digit;
    logic       last;
    logic       err;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    rdy_pct = 100;
  int    gap_pct = 0;
  int    op_a[MAXD+1];
  int    op_b[MAXD+1];

  xs3_serial_adder #(.MAX_DIGITS(MAXD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    beat_t e;
    if (exp_q.size() == 0) begin
      checkValue("spurious_beat", 8'(out_valid), 8'd0);
    end else begin
      e = exp_q.pop_front();
      checkValue("out_digit", 8'(out_digit), 8'(e.digit));
      checkValue("out_last", 8'(out_last), 8'(e.last));
      checkValue("err", 8'(err), 8'(e.err));
    end
  endtask

  function automatic logic rnd_ready();
    return int'($urandom_range(99)) < rdy_pct;
  endfunction

  // One cycle: drive after the falling edge, then sample and score before the rising edge.
  task automatic tick(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic l, input logic r, output logic took);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_last   = l;
    out_ready = r;
    #1;
    took = v && in_ready;
    if (out_valid && out_ready)
      checkOutput();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic l,
                               output int cycles);
    logic took;
    logic v;
    took   = 1'b0;
    cycles = 0;
    while (!took && cycles < 100) begin
      v = !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct);
      tick(v, a, b, l, rnd_ready(), took);
      cycles++;
    end
    if (!took)
      checkValue("accept_timeout", 8'd0, 8'd1);
  endtask

  task automatic drain();
    int   n;
    logic took;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick(1'b0, 4'd0, 4'd0, 1'b0, rnd_ready(), took);
      n++;
    end
    if (exp_q.size() > 0)
      checkValue("drain_timeout", 8'(exp_q.size()), 8'd0);
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, took);
  endtask

  // Reference: add the operands as decimal integers and split the sum back into digits.
  task automatic push_op(input int n, input bit no_last);
    longint a_val, b_val, s, q, p;
    beat_t  e;
    a_val = 0;
    b_val = 0;
    p     = 1;
    for (int i = 0; i < n; i++) begin
      a_val += longint'(op_a[i]) * p;
      b_val += longint'(op_b[i]) * p;
      p *= 10;
    end
    s = a_val + b_val;
    q = s;
    for (int i = 0; i < n; i++) begin
      e.digit = 4'((q % 10) + 3);
      e.last  = (i == n - 1) && (s < p);
      e.err   = no_last && (i == n - 1);
      exp_q.push_back(e);
      q /= 10;
    end
    if (s >= p) begin
      e.digit = 4'b0100;
      e.last  = 1'b1;
      e.err   = no_last;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_op(input int n, input bit no_last);
    int c;
    push_op(n, no_last);
    for (int i = 0; i < n; i++)
      applyStimulus(4'(op_a[i] + 3), 4'(op_b[i] + 3), !no_last && (i == n - 1), c);
    drain();
  endtask

  task automatic rand_fill(input int n);
    for (int i = 0; i < n; i++) begin
      op_a[i] = int'($urandom_range(9));
      op_b[i] = int'($urandom_range(9));
    end
  endtask

  initial begin
    logic  took;
    int    c;
    beat_t e;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("rst_out_valid", 8'(out_valid), 8'd0);
    checkValue("rst_out_digit", 8'(out_digit), 8'h3);
    checkValue("rst_out_last", 8'(out_last), 8'd0);
    checkValue("rst_err", 8'(err), 8'd0);
    rst_n = 1'b1;
    #1;
    checkValue("rst_in_ready", 8'(in_ready), 8'd1);

    $display("[TB] single digit 5+3");
    op_a[0] = 5; op_b[0] = 3;
    send_op(1, 1'b0);

    $display("[TB] carry flush 7+6");
    op_a[0] = 7; op_b[0] = 6;
    push_op(1, 1'b0);
    applyStimulus(4'b1010, 4'b1001, 1'b1, c);
    tick(1'b1, 4'h4, 4'h4, 1'b0, 1'b1, took);
    checkValue("flush_in_ready", 8'(in_ready), 8'd0);
    drain();

    $display("[TB] multi digit 99+01");
    op_a[0] = 9; op_a[1] = 9; op_b[0] = 1; op_b[1] = 0;
    send_op(2, 1'b0);

    $display("[TB] backpressure");
    op_a[0] = 1; op_a[1] = 2; op_a[2] = 3; op_a[3] = 4;
    op_b[0] = 5; op_b[1] = 6; op_b[2] = 7; op_b[3] = 8;
    push_op(4, 1'b0);
    applyStimulus(4'(op_a[0] + 3), 4'(op_b[0] + 3), 1'b0, c);
    applyStimulus(4'(op_a[1] + 3), 4'(op_b[1] + 3), 1'b0, c);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'(op_a[2] + 3), 4'(op_b[2] + 3), 1'b0, 1'b0, took);
      checkValue("bp_in_ready", 8'(in_ready), 8'd0);
      checkValue("bp_out_valid", 8'(out_valid), 8'd1);
      checkValue("bp_hold_digit", 8'(out_digit), 8'(exp_q[0].digit));
    end
    applyStimulus(4'(op_a[2] + 3), 4'(op_b[2] + 3), 1'b0, c);
    checkValue("bp_thru_a", 8'(c), 8'd1);
    applyStimulus(4'(op_a[3] + 3), 4'(op_b[3] + 3), 1'b1, c);
    checkValue("bp_thru_b", 8'(c), 8'd1);
    drain();

    $display("[TB] digit overflow");
    for (int i = 0; i <= MAXD; i++) begin
      op_a[i] = 4;
      op_b[i] = 5;
    end
    send_op(MAXD + 1, 1'b1);
    checkValue("err_sticky", 8'(err), 8'd1);
    op_a[0] = 5; op_b[0] = 3;
    send_op(1, 1'b0);

    $display("[TB] reset mid-operation");
    e.digit = 4'b0011; e.last = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    applyStimulus(4'b1000, 4'b1000, 1'b0, c);
    applyStimulus(4'b1100, 4'b1100, 1'b0, c);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkValue("pre_rst_digit", 8'(out_digit), 8'hC);
    rst_n = 1'b0;
    #1;
    checkValue("mid_rst_out_valid", 8'(out_valid), 8'd0);
    checkValue("mid_rst_out_digit", 8'(out_digit), 8'h3);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    op_a[0] = 0; op_b[0] = 0;
    send_op(1, 1'b0);

    $display("[TB] illegal code digit");
    e.digit = 4'b0000; e.last = 1'b1;
`ifdef XS3_CHECK_EN
    e.err = 1'b1;
`else
    e.err = 1'b0;
`endif
    exp_q.push_back(e);
    applyStimulus(4'b0000, 4'b0011, 1'b1, c);
    drain();
    op_a[0] = 2; op_b[0] = 2;
    send_op(1, 1'b0);

    $display("[TB] random operations");
    rdy_pct = 70;
    gap_pct = 20;
    for (int k = 0; k < 30; k++) begin
      c = int'($urandom_range(MAXD, 1));
      rand_fill(c);
      send_op(c, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      rand_fill(MAXD + 1);
      send_op(MAXD + 1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
